// File: rtl/dac_reconfig_sequencer_pkg.sv
// Shared types and defaults for the DAC reconfiguration sequencer.
package dac_reconfig_sequencer_pkg;

  // Sequencer states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DEBOUNCE   = 3'd1,
    ST_MUTE       = 3'd2,
    ST_HOLD_RESET = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_UNMUTE     = 3'd5
  } seq_state_e;

  // Packed MCU configuration word, MSB first.
  typedef struct packed {
    logic       mcu_44_48;
    logic [1:0] mcu_f;
    logic       mcu_dsd_on;
    logic       mcu_bit_6;
    logic       mcu_bit_8;
    logic       mcu_bit_10;
    logic       mclk_sel_chg;
  } cfg_t;

  // Bit positions of the cfg_t fields.
  localparam int CFG_B_MCLK_SEL_CHG = 0;
  localparam int CFG_B_BIT_10       = 1;
  localparam int CFG_B_BIT_8        = 2;
  localparam int CFG_B_BIT_6        = 3;
  localparam int CFG_B_DSD_ON       = 4;
  localparam int CFG_B_F_LO         = 5;
  localparam int CFG_B_44_48        = 7;

  localparam int CFG_W_DEF         = $bits(cfg_t);
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int MUTE_CYCLES_DEF   = 4096;
  localparam int RESET_CYCLES_DEF  = 256;
  localparam int SETTLE_CYCLES_DEF = 16384;

  // Largest of four cycle counts; sizes the shared timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dac_reconfig_sequencer_sync_vec.sv
// Two-flop synchroniser for a vector of independent, slowly changing bits.
module dac_reconfig_sequencer_sync_vec #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Plain two-stage capture; no reset so the first post-reset cycle sees live inputs.
  always_ff @(posedge clk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end

  assign q = sync_q;

endmodule

// File: rtl/dac_reconfig_sequencer.sv
// Mute / reset / reconfigure / settle / unmute sequencer for DAC format changes.
module dac_reconfig_sequencer
  import dac_reconfig_sequencer_pkg::*;
#(
  parameter int CFG_W         = CFG_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MUTE_CYCLES   = MUTE_CYCLES_DEF,
  parameter int RESET_CYCLES  = RESET_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] cfg_in,
  input  logic             force_reseq,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_apply,
  output logic             dac_mute_req,
  output logic             dac_reset_req,
  output logic             ready,
  output logic [2:0]       state
);

  localparam int MAX_CYC = max4(STABLE_CYCLES, MUTE_CYCLES, RESET_CYCLES, SETTLE_CYCLES);
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LD_STABLE = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] LD_MUTE   = TW'(MUTE_CYCLES - 1);
  localparam logic [TW-1:0] LD_RESET  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYCLES - 1);

  logic [CFG_W-1:0] cfg_s;
  logic             frc_s;

  dac_reconfig_sequencer_sync_vec #(.W(CFG_W)) u_sync_cfg (.clk(clk), .d(cfg_in),      .q(cfg_s));
  dac_reconfig_sequencer_sync_vec #(.W(1))     u_sync_frc (.clk(clk), .d(force_reseq), .q(frc_s));

  seq_state_e       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_out_q, cfg_out_d;
  logic             cfg_apply_q, cfg_apply_d;
  logic             mute_q, mute_d;
  logic             rst_q, rst_d;
  logic             ready_q, ready_d;
  logic             frc_prev_q;
  logic             init_q;
  logic             frc_rise;
  logic             tmr_zero;
  logic             ld_cfg;

  assign frc_rise = frc_s & ~frc_prev_q;
  assign tmr_zero = (tmr_q == '0);

  // State register plus the timer, shadow and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD_RESET;
      tmr_q       <= LD_RESET;
      shadow_q    <= '0;
      cfg_out_q   <= '0;
      cfg_apply_q <= 1'b0;
      mute_q      <= 1'b1;
      rst_q       <= 1'b1;
      ready_q     <= 1'b0;
      frc_prev_q  <= 1'b0;
      init_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      shadow_q    <= shadow_d;
      cfg_out_q   <= cfg_out_d;
      cfg_apply_q <= cfg_apply_d;
      mute_q      <= mute_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      frc_prev_q  <= frc_s;
      init_q      <= 1'b0;
    end
  end

  // Next state: every timed state is entered with N-1 and leaves when the timer hits zero.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_zero ? tmr_q : tmr_q - TW'(1);
    shadow_d = shadow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frc_rise) begin
          state_d = ST_MUTE;
          tmr_d   = LD_MUTE;
        end else if (cfg_s != cfg_out_q) begin
          state_d  = ST_DEBOUNCE;
          tmr_d    = LD_STABLE;
          shadow_d = cfg_s;
        end
      end
      ST_DEBOUNCE: begin
        if (frc_rise) begin
          state_d = ST_MUTE;
          tmr_d   = LD_MUTE;
        end else if (cfg_s != shadow_q) begin
          // Input still moving: restart the stability window on the new value.
          tmr_d    = LD_STABLE;
          shadow_d = cfg_s;
        end else if (shadow_q == cfg_out_q) begin
          state_d = mute_q ? ST_UNMUTE : ST_IDLE;
        end else if (tmr_zero) begin
          // Already muted (came from SETTLE): go straight to the DAC reset.
          state_d = mute_q ? ST_HOLD_RESET : ST_MUTE;
          tmr_d   = mute_q ? LD_RESET : LD_MUTE;
        end
      end
      ST_MUTE: begin
        if (tmr_zero) begin
          state_d = ST_HOLD_RESET;
          tmr_d   = LD_RESET;
        end
      end
      ST_HOLD_RESET: begin
        if (tmr_zero) begin
          state_d = ST_SETTLE;
          tmr_d   = LD_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          if (cfg_s != cfg_out_q) begin
            state_d  = ST_DEBOUNCE;
            tmr_d    = LD_STABLE;
            shadow_d = cfg_s;
          end else begin
            state_d = ST_UNMUTE;
          end
        end
      end
      ST_UNMUTE: state_d = ST_IDLE;
      default: begin
        state_d = ST_HOLD_RESET;
        tmr_d   = LD_RESET;
      end
    endcase
  end

  // Outputs decoded from the next state so they line up with state_q once registered.
  always_comb begin
    mute_d  = 1'b1;
    rst_d   = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      ST_IDLE: begin
        mute_d  = 1'b0;
        ready_d = 1'b1;
      end
      ST_DEBOUNCE:   mute_d = mute_q;
      ST_HOLD_RESET: rst_d  = 1'b1;
      default: ;
    endcase
    // New config is captured only when HOLD_RESET begins (or just after reset release).
    ld_cfg      = init_q | ((state_d == ST_HOLD_RESET) & (state_q != ST_HOLD_RESET));
    cfg_out_d   = ld_cfg ? cfg_s : cfg_out_q;
    cfg_apply_d = ld_cfg;
  end

  assign cfg_out       = cfg_out_q;
  assign cfg_apply     = cfg_apply_q;
  assign dac_mute_req  = mute_q;
  assign dac_reset_req = rst_q;
  assign ready         = ready_q;
  assign state         = state_q;

endmodule

// File: tb/tb_dac_reconfig_sequencer.sv
// Directed bench for dac_reconfig_sequencer with a cycle-level reference model.
module tb_dac_reconfig_sequencer;

  localparam int T_STABLE = 4;
  localparam int T_MUTE   = 8;
  localparam int T_RESET  = 4;
  localparam int T_SETTLE = 16;

  localparam int P_IDLE = 0, P_DEB = 1, P_MUTE = 2, P_HOLD = 3, P_SETTLE = 4, P_UNMUTE = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cfg_in = 8'h25;
  logic       force_reseq = 1'b0;
  logic [7:0] cfg_out;
  logic       cfg_apply, dac_mute_req, dac_reset_req, ready;
  logic [2:0] state;

  int nchk = 0;
  int nerr = 0;

  dac_reconfig_sequencer #(
    .CFG_W(8), .STABLE_CYCLES(T_STABLE), .MUTE_CYCLES(T_MUTE),
    .RESET_CYCLES(T_RESET), .SETTLE_CYCLES(T_SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .cfg_in(cfg_in), .force_reseq(force_reseq),
    .cfg_out(cfg_out), .cfg_apply(cfg_apply), .dac_mute_req(dac_mute_req),
    .dac_reset_req(dac_reset_req), .ready(ready), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles spent in it, with a 2-deep input delay line.
  int         m_ph, m_el;
  logic [7:0] m_out, m_shadow, m_c1, m_c2;
  logic       m_app, m_mute, m_first, m_f1, m_f2, m_fprev;
  logic       m_valid = 1'b0;

  initial begin
    m_c1 = 8'h00; m_c2 = 8'h00; m_f1 = 1'b0; m_f2 = 1'b0;
  end

  always @(posedge clk) begin : model
    logic [7:0] s;
    logic       rise, ld;
    int         nxt, el_n;
    if (reset) begin
      m_ph = P_HOLD; m_el = 1; m_out = 8'h00; m_app = 1'b0; m_mute = 1'b1;
      m_first = 1'b1; m_shadow = 8'h00; m_fprev = 1'b0; m_valid = 1'b1;
    end else begin
      s = m_c2;
      rise = m_f2 & ~m_fprev;
      m_fprev = m_f2;
      nxt = m_ph;
      el_n = m_el + 1;
      case (m_ph)
        P_IDLE:
          if (rise) begin nxt = P_MUTE; el_n = 1; end
          else if (s != m_out) begin nxt = P_DEB; el_n = 1; m_shadow = s; end
        P_DEB:
          if (rise) begin nxt = P_MUTE; el_n = 1; end
          else if (s != m_shadow) begin m_shadow = s; el_n = 1; end
          else if (m_shadow == m_out) begin nxt = m_mute ? P_UNMUTE : P_IDLE; el_n = 1; end
          else if (m_el == T_STABLE) begin nxt = m_mute ? P_HOLD : P_MUTE; el_n = 1; end
        P_MUTE:
          if (m_el == T_MUTE) begin nxt = P_HOLD; el_n = 1; end
        P_HOLD:
          if (m_el == T_RESET) begin nxt = P_SETTLE; el_n = 1; end
        P_SETTLE:
          if (m_el == T_SETTLE) begin
            el_n = 1;
            if (s != m_out) begin nxt = P_DEB; m_shadow = s; end
            else nxt = P_UNMUTE;
          end
        default: begin nxt = P_IDLE; el_n = 1; end
      endcase
      ld = m_first || (nxt == P_HOLD && m_ph != P_HOLD);
      m_app = ld;
      if (ld) m_out = s;
      m_first = 1'b0;
      if (nxt == P_IDLE) m_mute = 1'b0;
      else if (nxt != P_DEB) m_mute = 1'b1;
      m_ph = nxt;
      m_el = el_n;
    end
    m_c2 = m_c1; m_c1 = cfg_in;
    m_f2 = m_f1; m_f1 = force_reseq;
  end

  // Per-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", state, m_ph);
      chk("cfg_out", cfg_out, m_out);
      chk("cfg_apply", cfg_apply, m_app);
      chk("mute", dac_mute_req, m_mute);
      chk("dac_reset", dac_reset_req, m_ph == P_HOLD);
      chk("ready", ready, m_ph == P_IDLE);
      chk("inv_reset_implies_mute", dac_reset_req & ~dac_mute_req, 0);
    end
  end

  // Runs until ready has dropped and come back; optionally changes cfg_in at cycle chg_at.
  task automatic measure(input int lim, input int chg_at, input logic [7:0] chg_val,
                         output int n, output int n_app, output int app_at,
                         output int n_rst, output int n_mute, output int n_fall);
    logic low_seen, pm, done;
    n = 0; n_app = 0; app_at = -1; n_rst = 0; n_mute = 0; n_fall = 0;
    low_seen = 1'b0; done = 1'b0; pm = dac_mute_req;
    while (n < lim && !done) begin
      @(negedge clk);
      n++;
      if (cfg_apply) begin
        n_app++;
        if (app_at < 0) app_at = n;
      end
      n_rst  += int'(dac_reset_req);
      n_mute += int'(dac_mute_req);
      if (pm && !dac_mute_req) n_fall++;
      pm = dac_mute_req;
      if (n == chg_at) cfg_in = chg_val;
      if (!ready) low_seen = 1'b1;
      else if (low_seen) done = 1'b1;
    end
    chk("sequence_completes", done, 1);
  endtask

  initial begin
    int n, na, aa, nr, nm, nf, tm, ta;

    // 1: reset state and release with cfg 0x25
    repeat (5) @(negedge clk);
    chk("t1_reset_state", state, 3);
    chk("t1_reset_mute", dac_mute_req, 1);
    chk("t1_reset_dacrst", dac_reset_req, 1);
    chk("t1_reset_ready", ready, 0);
    chk("t1_reset_cfg", cfg_out, 0);
    chk("t1_reset_apply", cfg_apply, 0);
    reset = 1'b0;
    measure(100, -1, 8'h00, n, na, aa, nr, nm, nf);
    chk("t1_ready_latency", n, 21);
    chk("t1_apply_cycle", aa, 1);
    chk("t1_apply_count", na, 1);
    chk("t1_dacrst_cycles_after_release", nr, 3);
    chk("t1_mute_cycles", nm, 20);
    chk("t1_cfg_out", cfg_out, 8'h25);

    // 2: held change 0x25 -> 0x45
    repeat (3) @(negedge clk);
    cfg_in = 8'h45;
    measure(200, -1, 8'h00, n, na, aa, nr, nm, nf);
    chk("t2_ready_latency", n, 36);
    chk("t2_apply_cycle", aa, 15);
    chk("t2_apply_count", na, 1);
    chk("t2_dacrst_cycles", nr, 4);
    chk("t2_mute_cycles", nm, 29);
    chk("t2_unmute_count", nf, 1);
    chk("t2_cfg_out", cfg_out, 8'h45);

    // back to 0x25 for the glitch case
    repeat (3) @(negedge clk);
    cfg_in = 8'h25;
    measure(200, -1, 8'h00, n, na, aa, nr, nm, nf);
    chk("t2b_ready_latency", n, 36);
    chk("t2b_cfg_out", cfg_out, 8'h25);

    // 3: two-cycle glitch 0x25 -> 0x45 -> 0x25
    repeat (3) @(negedge clk);
    cfg_in = 8'h45;
    measure(100, 2, 8'h25, n, na, aa, nr, nm, nf);
    chk("t3_ready_back", n, 6);
    chk("t3_mute_cycles", nm, 0);
    chk("t3_apply_count", na, 0);
    chk("t3_cfg_out", cfg_out, 8'h25);

    // 4: input toggling every 3 cycles, then held at 0x65
    repeat (3) @(negedge clk);
    tm = 0; ta = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) cfg_in = ((i / 3) % 2 != 0) ? 8'h55 : 8'h45;
      @(negedge clk);
      tm += int'(dac_mute_req);
      ta += int'(cfg_apply);
    end
    chk("t4_mute_during_toggle", tm, 0);
    chk("t4_apply_during_toggle", ta, 0);
    cfg_in = 8'h65;
    measure(200, -1, 8'h00, n, na, aa, nr, nm, nf);
    chk("t4_ready_latency", n, 36);
    chk("t4_apply_count", na, 1);
    chk("t4_unmute_count", nf, 1);
    chk("t4_cfg_out", cfg_out, 8'h65);

    // 5: change to 0x85 during SETTLE of a 0x75 sequence
    repeat (3) @(negedge clk);
    cfg_in = 8'h75;
    measure(300, 25, 8'h85, n, na, aa, nr, nm, nf);
    chk("t5_ready_latency", n, 60);
    chk("t5_apply_count", na, 2);
    chk("t5_first_apply", aa, 15);
    chk("t5_dacrst_cycles", nr, 8);
    chk("t5_mute_cycles", nm, 53);
    chk("t5_unmute_count", nf, 1);
    chk("t5_cfg_out", cfg_out, 8'h85);

    // 6: force_reseq rising in IDLE, held high afterwards
    repeat (3) @(negedge clk);
    force_reseq = 1'b1;
    measure(200, -1, 8'h00, n, na, aa, nr, nm, nf);
    chk("t6_ready_latency", n, 32);
    chk("t6_apply_cycle", aa, 11);
    chk("t6_apply_count", na, 1);
    chk("t6_dacrst_cycles", nr, 4);
    chk("t6_mute_cycles", nm, 29);
    chk("t6_cfg_out", cfg_out, 8'h85);
    repeat (5) @(negedge clk);
    chk("t6_level_no_retrigger", ready, 1);
    force_reseq = 1'b0;
    repeat (3) @(negedge clk);
    force_reseq = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_in_mute", state, 2);
    chk("t6_in_mute_mute", dac_mute_req, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_midreset_state", state, 3);
    chk("t6_midreset_mute", dac_mute_req, 1);
    chk("t6_midreset_dacrst", dac_reset_req, 1);
    chk("t6_midreset_cfg", cfg_out, 0);
    chk("t6_midreset_ready", ready, 0);
    reset = 1'b0;
    measure(100, -1, 8'h00, n, na, aa, nr, nm, nf);
    chk("t6_rerelease_latency", n, 21);
    chk("t6_rerelease_apply_cycle", aa, 1);
    chk("t6_rerelease_cfg", cfg_out, 8'h85);
    force_reseq = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dac_reconfig_sequencer.md
Name: dac_reconfig_sequencer

Overview:
- Sequences every DAC format or clock change: MCU mode change → mute DAC → pulse DAC reset and apply new configuration → wait for clocks/PLL to settle → unmute.
- Sits between the MCU control inputs and the DAC control, MCLK-select and NOS datapath configuration, all in the `clk` domain.
- Downstream DAC control and the MCLK mux consume only `cfg_out`, never raw MCU pins.
- `dac_mute_req` and `dac_reset_req` are positive-true; the top level applies the jumper polarity.

Parameters:
- CFG_W, 8, width of packed configuration word (`CFG_T` in common).
- STABLE_CYCLES, 1024, cycles `cfg_in` must be unchanged before a change is accepted.
- MUTE_CYCLES, 4096, cycles of mute before DAC reset.
- RESET_CYCLES, 256, width of DAC reset pulse.
- SETTLE_CYCLES, 16384, post-reset settle time for PLL/MCLK mux and DAC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_in  in  CFG_W  raw MCU config: {mcu_44_48, mcu_f[1:0], mcu_dsd_on, mcu_bit_6, mcu_bit_8, mcu_bit_10, mclk_sel_chg}; asynchronous.
- force_reseq  in  1  request a full resequence, e.g. from mcu_dac_reset; level, asynchronous.
- cfg_out  out  CFG_W  applied configuration, drives DAC control and MCLK select.
- cfg_apply  out  1  one-cycle pulse when `cfg_out` is loaded.
- dac_mute_req  out  1  1 = DAC muted.
- dac_reset_req  out  1  1 = DAC held in reset.
- ready  out  1  1 only in IDLE: configuration stable, audio passing.
- state  out  3  current `SEQ_STATE`, for debug and indication.

Behaviour:
- Input synchronisation:
  - `cfg_in` and `force_reseq` pass through a 2-flop synchroniser; 2 cycles of latency.
  - Below, `cfg_s` and `frc_s` denote the synchronised values.
  - `frc_s` is edge-detected; only a 0→1 transition counts.
- Timer: one down-counter, wide enough for the largest parameter.
  - Loaded with N-1 on entry to a timed state; the state lasts exactly N cycles.
  - A state exits on the cycle the count reaches 0.
- Reset values:
  - state=HOLD_RESET, `cfg_out`=0, `cfg_apply`=0, `dac_mute_req`=1, `dac_reset_req`=1, `ready`=0.
  - Timer loaded with RESET_CYCLES-1.
  - `cfg_out` loads `cfg_s` on the first cycle after reset release, with a `cfg_apply` pulse.
- States and transitions:
  - IDLE:
    - Outputs: mute=0, reset=0, ready=1.
    - `frc_s` rising → MUTE.
    - Else `cfg_s`≠`cfg_out` → DEBOUNCE.
  - DEBOUNCE:
    - Captures `cfg_s` into a shadow register; mute unchanged.
    - Any `cfg_s` change during the count reloads the timer and the shadow.
    - `frc_s` rising → MUTE.
    - Shadow returns equal to `cfg_out`: → IDLE if mute=0, → UNMUTE if mute=1.
    - Timer expiry → MUTE if mute=0, → HOLD_RESET if mute=1.
  - MUTE:
    - mute=1 for MUTE_CYCLES, then → HOLD_RESET.
  - HOLD_RESET:
    - On entry: `cfg_out`←`cfg_s` and `cfg_apply`=1 for one cycle.
    - mute=1, reset=1 for RESET_CYCLES.
    - `cfg_s` changes during this state are ignored.
    - Exit → SETTLE.
  - SETTLE:
    - mute=1, reset=0 for SETTLE_CYCLES.
    - On expiry: `cfg_s`≠`cfg_out` → DEBOUNCE, with mute held. Else → UNMUTE.
  - UNMUTE:
    - One cycle; mute deasserts on exit; → IDLE.
- `frc_s` edges in MUTE, HOLD_RESET, SETTLE or UNMUTE are ignored; a sequence is already in progress.
- Invariants:
  - `dac_reset_req`=1 implies `dac_mute_req`=1.
  - `cfg_out` changes only in the first cycle of HOLD_RESET.
  - Audio is never unmuted with `cfg_out`≠the value applied before the last reset.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted in any state returns to reset values on the next edge.

Decomposition:
- Shared package `common`:
  - `SEQ_STATE` enum {IDLE, DEBOUNCE, MUTE, HOLD_RESET, SETTLE, UNMUTE}.
  - `CFG_T` packed struct, with field-order constants.
  - Default timing constants.
- One sub-module: `sync_vec`, a parameterised-width 2-flop synchroniser, reused for `cfg_in` and `force_reseq`.

Test Plan:
All scenarios run with STABLE=4, MUTE=8, RESET=4, SETTLE=16.
1. Reset release with `cfg_in`=8'h25 → `cfg_out`=8'h25 and `cfg_apply` pulse on cycle 1; `dac_reset_req` high 4 cycles; mute high; `ready`=1 exactly 21 cycles after release.
2. In IDLE, `cfg_in` 8'h25→8'h45 held → after 2 sync cycles: DEBOUNCE 4 cycles, then mute=1; 8 cycles later reset=1 and `cfg_out`=8'h45; `ready` returns after 4+8+4+16+1 cycles.
3. Glitch: `cfg_in` 8'h25→8'h45→8'h25 within 2 cycles in IDLE → enters DEBOUNCE, returns to IDLE; mute never asserts, `cfg_out` stays 8'h25.
4. `cfg_in` toggled every 3 cycles for 40 cycles, then held at 8'h65 → DEBOUNCE restarts each time; single sequence afterwards; final `cfg_out`=8'h65 with one `cfg_apply` pulse.
5. `cfg_in` changes to 8'h85 during SETTLE → at SETTLE expiry goes to DEBOUNCE with mute held at 1 (no unmute glitch); then HOLD_RESET directly, skipping MUTE; `cfg_out`=8'h85.
6. `force_reseq` pulse in IDLE → MUTE with no debounce; `cfg_out` unchanged, reloaded with the same value. Reset asserted mid-MUTE → next cycle state=HOLD_RESET, mute=1, reset=1.
